mdu_hilo: RTL and testbench

- Iterative multiply/divide unit for the pipelined CPU's EX stage; owns the HI/LO registers.
- Consumes rs/rt operands already selected by the EX-stage forwarding muxes.
- hi_o/lo_o feed the writeback-select mux (MFHI/MFLO path).
- busy_o feeds the hazard unit, which stalls IF/ID/EX while an operation is in flight.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_iter_core.sv | 42 ++++
 rtl/mdu_hilo.sv | 118 +++++++++++
 tb/tb_mdu_hilo.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: operation and FSM state encodings shared by the multiply/divide unit.
package mdu_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;
endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: unsigned shift-add multiply / restoring divide, one step per enable.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  // acc holds {upper, multiplier} for multiply and {remainder, quotient} for divide
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, rem_d;
  logic [WIDTH:0]     sum, shifted;
  logic               div_q, ge;
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge      = shifted >= {1'b0, b_q};
    rem_d   = ge ? WIDTH'(shifted - {1'b0, b_q}) : shifted[WIDTH-1:0];
    acc_d   = div_q ? {rem_d, acc_q[WIDTH-2:0], ge} : {sum, acc_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, a_i};
      b_q   <= b_i;
      div_q <= div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end
  assign hi_o = acc_q[2*WIDTH-1:WIDTH];
  assign lo_o = acc_q[WIDTH-1:0];
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/DIV unit owning HI/LO; MDU_FAST_MUL_EN selects a single-cycle multiplier.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q, dvd_q, a_abs, b_abs, core_hi, core_lo, q_fix, r_fix, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic               neg_q, rneg_q, dz_q, div_q, done_q;
  logic               is_md, is_sgn, is_div, issue, fast, fin_wr;
  assign is_md  = op_i == OP_MULT || op_i == OP_MULTU || op_i == OP_DIV || op_i == OP_DIVU;
  assign is_sgn = op_i == OP_MULT || op_i == OP_DIV;
  assign is_div = op_i == OP_DIV || op_i == OP_DIVU;
  assign issue  = start_i && !cancel_i && state_q == S_IDLE;
  assign fin_wr = state_q == S_FIN && !cancel_i;
  assign a_abs  = (is_sgn && rs_i[WIDTH-1]) ? -rs_i : rs_i;
  assign b_abs  = (is_sgn && rt_i[WIDTH-1]) ? -rt_i : rt_i;
`ifdef MDU_FAST_MUL_EN
  logic               fast_q;
  logic [2*WIDTH-1:0] prod_q;
  assign fast = op_i == OP_MULT || op_i == OP_MULTU;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fast_q <= 1'b0;
      prod_q <= '0;
    end else if (issue && is_md) begin
      fast_q <= fast;
      prod_q <= {{WIDTH{is_sgn & rs_i[WIDTH-1]}}, rs_i} * {{WIDTH{is_sgn & rt_i[WIDTH-1]}}, rt_i};
    end
  end
`else
  assign fast = 1'b0;
`endif
  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (issue && is_md && !fast),
    .step_i (state_q == S_RUN),
    .div_i  (is_div),
    .a_i    (a_abs),
    .b_i    (b_abs),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );
  always_comb begin
    prod_fix = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    q_fix    = neg_q ? -core_lo : core_lo;
    r_fix    = rneg_q ? -core_hi : core_hi;
    res_hi   = dz_q ? dvd_q : div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = dz_q ? '1 : div_q ? q_fix : prod_fix[WIDTH-1:0];
`ifdef MDU_FAST_MUL_EN
    if (fast_q) {res_hi, res_lo} = prod_q;
`endif
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cancel_i) state_d = S_IDLE;
    else if (state_q == S_IDLE) begin
      if (start_i && is_md) begin
        state_d = fast ? S_FIN : S_RUN;
        cnt_d   = '0;
      end
    end else if (state_q == S_RUN) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FIN : S_RUN;
    end else state_d = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= fin_wr;
      if (issue && is_md) begin
        neg_q  <= is_sgn & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
        rneg_q <= is_sgn & is_div & rs_i[WIDTH-1];
        dz_q   <= is_div & (rt_i == '0);
        div_q  <= is_div;
        dvd_q  <= rs_i;
      end
      if (fin_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (issue && op_i == OP_MTHI) hi_q <= rs_i;
      else if (issue && op_i == OP_MTLO) lo_q <= rs_i;
    end
  end
  assign busy_o = state_q != S_IDLE;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: random + directed scoreboard bench; define MDU_FAST_MUL_EN to check the fast multiplier.
module tb_mdu_hilo;
  import mdu_pkg::*;
  logic        clk = 0, rst_n = 0, start_i = 0, cancel_i = 0;
  logic [2:0]  op_i = 0;
  logic [31:0] rs_i = 0, rt_i = 0, hi_o, lo_o, m_hi = 0, m_lo = 0;
  logic        busy_o, done_o;
  logic [63:0] exp_q[$];
  int          total = 0, bad = 0;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1;
`else
  localparam bit FAST = 0;
`endif
  mdu_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .cancel_i(cancel_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (op == OP_MULTU) return {32'b0, a} * {32'b0, b};
    if (op == OP_MULT) begin
      p = longint'(sa) * longint'(sb);
      return p;
    end
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == OP_DIVU) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction
  // scoreboard monitor: every done pulse must match the oldest outstanding result
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (exp_q.size() == 0) chk("spurious_done", {hi_o, lo_o}, 64'hx);
      else chk("result", {hi_o, lo_o}, exp_q.pop_front());
    end
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic cx);
    @(negedge clk);
    start_i = 1; op_i = op; rs_i = a; rt_i = b; cancel_i = cx;
    @(posedge clk); #1;
    start_i = 0; op_i = OP_NONE; cancel_i = 0;
  endtask
  task automatic md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int n;
    e = model(op, a, b);
    exp_q.push_back(e);
    issue(op, a, b, 0);
    n = 0;
    while (busy_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_cycles", 64'(n), (FAST && (op == OP_MULT || op == OP_MULTU)) ? 64'd1 : 64'd33);
    {m_hi, m_lo} = e;
    @(negedge clk);
  endtask
  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    issue(op, a, 0, 0);
    if (op == OP_MTHI) m_hi = a; else m_lo = a;
    chk("mt_busy", 64'(busy_o), 64'd0);
    chk("mt_hilo", {hi_o, lo_o}, {m_hi, m_lo});
  endtask
  task automatic abort(input int cyc);
    issue(OP_DIVU, 32'd1000, 32'd7, 0);
    repeat (cyc) @(posedge clk);
    #1 cancel_i = 1;
    @(posedge clk); #1 cancel_i = 0;
    chk("cancel_busy", 64'(busy_o), 64'd0);
    chk("cancel_hilo", {hi_o, lo_o}, {m_hi, m_lo});
    repeat (40) @(posedge clk);
  endtask
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst_n = 1;
    md(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    md(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    md(OP_DIV, -32'sd7, 32'd2);
    md(OP_DIVU, 32'd100, 32'd0);
    md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    md(OP_DIV, 32'hFFFF_FFF0, 32'd0);
    md(OP_MULTU, 32'd3, 32'd5);
    mt(OP_MTHI, 32'h1234);
    mt(OP_MTLO, 32'hABCD);
    issue(OP_MTHI, 32'hDEAD, 0, 1);
    chk("cancel_idle_hilo", {hi_o, lo_o}, {m_hi, m_lo});
    chk("cancel_idle_busy", 64'(busy_o), 64'd0);
    abort(10);
    abort(32);
    issue(OP_DIVU, 32'd77, 32'd5, 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    m_hi = 0; m_lo = 0;
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    repeat (40) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if (op >= OP_MTHI) mt(op, a); else md(op, a, b);
    end
    repeat (5) @(posedge clk);
    chk("pending", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
